// File: rtl/ntt_pkg.sv
// Shared constants, state encoding and twiddle-address helpers for the
// radix-4 NTT stage scheduler.
package ntt_pkg;

  localparam int N_LOG2  = 8;
  localparam int STAGES  = N_LOG2 / 2;
  localparam int ADDR_W  = N_LOG2 - 2;
  localparam int TW_W    = 7;
  localparam int STAGE_W = 2;
  // Index of the last twiddle entry; the inverse table is stored mirrored about it.
  localparam int TW_LAST = ((1 << (2 * STAGES)) - 1) / 3 - 1;

  localparam logic MODE_NTT  = 1'b0;
  localparam logic MODE_INTT = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    FINISH
  } sched_state_e;

  function automatic logic [TW_W-1:0] tw_base(input int s);
    int p;
    p = 1 << (2 * s);
    return TW_W'((p - 1) / 3);
  endfunction

  function automatic logic [TW_W-1:0] tw_addr_calc(
    input logic [STAGE_W-1:0] s,
    input logic [ADDR_W-1:0]  cnt,
    input logic               inv
  );
    logic [ADDR_W-1:0] grp;
    logic [TW_W-1:0]   fwd;
    grp = cnt >> (2 * (STAGES - 1 - int'(s)));
    fwd = tw_base(int'(s)) + TW_W'(grp);
    return inv ? (TW_W'(TW_LAST) - fwd) : fwd;
  endfunction

endpackage

// File: rtl/ntt_r4_sched_if.sv
// Control/address bundle between the NTT controller, the stage scheduler
// and the butterfly array / coefficient memory.
interface ntt_r4_sched_if import ntt_pkg::*; ();

  logic               start;
  logic               mode;
  logic               busy;
  logic               done;
  logic               sel;
  logic [STAGE_W-1:0] stage;
  logic               rd_en;
  logic [ADDR_W-1:0]  rd_addr;
  logic [TW_W-1:0]    tw_addr;
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;

  modport master (
    output start, mode,
    input  busy, done, sel, stage, rd_en, rd_addr, tw_addr, wr_en, wr_addr
  );

  modport slave (
    input  start, mode,
    output busy, done, sel, stage, rd_en, rd_addr, tw_addr, wr_en, wr_addr
  );

endinterface

// File: rtl/ntt_r4_sched_delay_line.sv
// Fixed-depth shift register used to align write-back (and later twiddle)
// strobes/addresses with the butterfly pipeline.
module sched_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH-1:0][WIDTH-1:0] pipe_q;
  logic [DEPTH-1:0][WIDTH-1:0] pipe_d;

  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = din;
    for (int i = 1; i < DEPTH; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/ntt_r4_sched.sv
// Stage scheduler for the 4-PE radix-4 butterfly array: walks every stage of
// one transform, emits read/twiddle addresses and BF_LAT-delayed write-backs.
module ntt_r4_sched import ntt_pkg::*; #(
  parameter int BF_LAT = 4
) (
  input  logic           clk,
  input  logic           rst,
  ntt_r4_sched_if.slave  bus
);

  localparam int DRN_W = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;

  sched_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  cnt_q, cnt_d;
  logic [STAGE_W-1:0] stage_q, stage_d;
  logic [DRN_W-1:0]   drn_q, drn_d;
  logic               sel_q, sel_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               rd_en_q, rd_en_d;
  logic [TW_W-1:0]    tw_q, tw_d;
  logic [ADDR_W:0]    wb_dout;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    drn_d   = drn_q;
    sel_d   = sel_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          sel_d   = bus.mode;
          stage_d = '0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        // Leave at all-ones so the group counter never wraps inside a stage.
        if (cnt_q == '1) begin
          state_d = DRAIN;
          drn_d   = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      DRAIN: begin
        if (drn_q == DRN_W'(BF_LAT - 1)) begin
          if (stage_q == STAGE_W'(STAGES - 1)) begin
            state_d = FINISH;
          end else begin
            state_d = RUN;
            stage_d = stage_q + STAGE_W'(1);
          end
        end else begin
          drn_d = drn_q + DRN_W'(1);
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered off the next state so they line up with cnt_q.
    rd_en_d = (state_d == RUN);
    busy_d  = (state_d == RUN) || (state_d == DRAIN);
    done_d  = (state_d == FINISH);
    tw_d    = tw_addr_calc(stage_d, cnt_d, sel_d == MODE_INTT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      stage_q <= '0;
      drn_q   <= '0;
      sel_q   <= MODE_NTT;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      tw_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      drn_q   <= drn_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rd_en_q <= rd_en_d;
      tw_q    <= tw_d;
    end
  end

  // The drain between stages guarantees this line is empty at each boundary.
  sched_delay_line #(
    .WIDTH (ADDR_W + 1),
    .DEPTH (BF_LAT)
  ) u_wb_dly (
    .clk  (clk),
    .rst  (rst),
    .din  ({rd_en_q, cnt_q}),
    .dout (wb_dout)
  );

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.sel     = sel_q;
  assign bus.stage   = stage_q;
  assign bus.rd_en   = rd_en_q;
  assign bus.rd_addr = cnt_q;
  assign bus.tw_addr = tw_q;
  assign bus.wr_en   = wb_dout[ADDR_W];
  assign bus.wr_addr = wb_dout[ADDR_W-1:0];

endmodule

// File: tb/tb_ntt_r4_sched.sv
// Directed bench for ntt_r4_sched: expected read/write-back streams are queued
// at each accepted start and retired as the scheduler emits them.
module tb_ntt_r4_sched;

  logic        clk;
  logic        rst;
  int unsigned cyc;
  int unsigned checks;
  int unsigned errors;

  typedef struct {
    int unsigned cyc;
    int unsigned stage;
    int unsigned addr;
    int unsigned tw;
  } exp_t;

  exp_t        exp_rd[$];
  exp_t        exp_wr[$];
  bit          mon_en;
  int unsigned rd_cnt;
  int unsigned done_cnt;
  int unsigned last_wr_cyc;
  int unsigned tw_s0, tw_s1_16, tw_s3_first, tw_s3_last;

  ntt_r4_sched_if bus ();

  ntt_r4_sched #(.BF_LAT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference stream: stage s, group c is read at 1 + s*68 + c cycles after the start cycle.
  task automatic push_expect(input logic m, input int unsigned c0);
    exp_t e;
    int unsigned fwd;
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 64; c++) begin
        fwd     = ((4 ** s) - 1) / 3 + (c >> (2 * (3 - s)));
        e.cyc   = c0 + 1 + s * 68 + c;
        e.stage = s;
        e.addr  = c;
        e.tw    = m ? (84 - fwd) : fwd;
        exp_rd.push_back(e);
        e.cyc   = e.cyc + 4;
        exp_wr.push_back(e);
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en && rst === 1'b1) begin
      if (bus.rd_en === 1'b1) begin
        rd_cnt++;
        if (exp_rd.size() == 0) begin
          chk("rd_unexpected", 32'(exp_rd.size()), 1);
        end else begin
          e = exp_rd.pop_front();
          chk("rd_cycle", cyc, e.cyc);
          chk("rd_addr", 32'(bus.rd_addr), e.addr);
          chk("tw_addr", 32'(bus.tw_addr), e.tw);
          chk("rd_stage", 32'(bus.stage), e.stage);
          if (e.addr == 0 && e.stage > 0) chk("drain_order", 32'(last_wr_cyc < cyc), 1);
          if (e.stage == 0 && e.addr == 0)  tw_s0       = 32'(bus.tw_addr);
          if (e.stage == 1 && e.addr == 16) tw_s1_16    = 32'(bus.tw_addr);
          if (e.stage == 3 && e.addr == 0)  tw_s3_first = 32'(bus.tw_addr);
          if (e.stage == 3 && e.addr == 63) tw_s3_last  = 32'(bus.tw_addr);
        end
      end
      if (bus.wr_en === 1'b1) begin
        last_wr_cyc = cyc;
        if (exp_wr.size() == 0) begin
          chk("wr_unexpected", 32'(exp_wr.size()), 1);
        end else begin
          e = exp_wr.pop_front();
          chk("wr_cycle", cyc, e.cyc);
          chk("wr_addr", 32'(bus.wr_addr), e.addr);
        end
      end
      if (bus.done === 1'b1) done_cnt++;
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},    32'(bus.busy), 0);
    chk({tag, "_done"},    32'(bus.done), 0);
    chk({tag, "_sel"},     32'(bus.sel), 0);
    chk({tag, "_stage"},   32'(bus.stage), 0);
    chk({tag, "_rd_en"},   32'(bus.rd_en), 0);
    chk({tag, "_rd_addr"}, 32'(bus.rd_addr), 0);
    chk({tag, "_tw_addr"}, 32'(bus.tw_addr), 0);
    chk({tag, "_wr_en"},   32'(bus.wr_en), 0);
    chk({tag, "_wr_addr"}, 32'(bus.wr_addr), 0);
  endtask

  // Called at a negedge; returns at the negedge of the done cycle.
  task automatic run_transform(input logic m, input bit pulse_mid, input bit hold_end);
    int unsigned c0;
    int unsigned rel;
    bit          got;
    bus.start = 1'b1;
    bus.mode  = m;
    c0        = cyc;
    rd_cnt    = 0;
    done_cnt  = 0;
    push_expect(m, c0);
    @(negedge clk);
    bus.start = 1'b0;
    bus.mode  = ~m;
    chk("busy_rise", 32'(bus.busy), 1);
    got = 1'b0;
    rel = 0;
    for (int n = 0; n < 400 && !got; n++) begin
      rel = cyc - c0;
      chk("sel_hold", 32'(bus.sel), 32'(m));
      if (bus.done === 1'b1) begin
        got = 1'b1;
      end else begin
        if (bus.busy !== 1'b1) chk("busy_hold", 32'(bus.busy), 1);
        if (pulse_mid) bus.start = (rel == 100);
        if (hold_end && rel >= 270) bus.start = 1'b1;
        @(negedge clk);
      end
    end
    chk("done_seen", 32'(got), 1);
    // Counting the start cycle as the first, done is the 274th cycle.
    chk("done_latency", rel + 1, 274);
    chk("busy_at_done", 32'(bus.busy), 0);
    chk("rd_count", rd_cnt, 256);
  endtask

  initial begin
    bit found;
    checks      = 0;
    errors      = 0;
    mon_en      = 1'b0;
    last_wr_cyc = 0;
    rst         = 1'b0;
    bus.start   = 1'b0;
    bus.mode    = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst    = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    // Forward transform.
    run_transform(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("done_pulse_width", 32'(bus.done), 0);
    chk("done_count_fwd", done_cnt, 1);
    chk("tw_fwd_s0", tw_s0, 0);
    chk("tw_fwd_s1_16", tw_s1_16, 2);
    chk("tw_fwd_s3_first", tw_s3_first, 21);
    chk("tw_fwd_s3_last", tw_s3_last, 84);
    repeat (3) @(negedge clk);

    // Inverse transform; start pulsed mid-run and held high across done.
    run_transform(1'b1, 1'b1, 1'b1);
    @(negedge clk);
    chk("done_pulse_width_inv", 32'(bus.done), 0);
    chk("done_count_inv", done_cnt, 1);
    chk("tw_inv_s0", tw_s0, 84);
    chk("tw_inv_s1_16", tw_s1_16, 82);
    chk("tw_inv_s3_first", tw_s3_first, 63);
    chk("tw_inv_s3_last", tw_s3_last, 0);

    // start still high one cycle after done: accepted as a fresh forward run.
    run_transform(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("done_count_back2back", done_cnt, 1);
    chk("tw_b2b_s3_first", tw_s3_first, 21);
    repeat (3) @(negedge clk);

    // Abort in stage 2 at group 30.
    mon_en    = 1'b0;
    bus.start = 1'b1;
    bus.mode  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 400 && !found; n++) begin
      if (bus.stage === 2'd2 && bus.rd_en === 1'b1 && bus.rd_addr === 6'd30) found = 1'b1;
      else @(negedge clk);
    end
    chk("abort_point_reached", 32'(found), 1);
    rst = 1'b0;
    #1;
    chk_all_zero("async_reset");
    exp_rd.delete();
    exp_wr.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    done_cnt = 0;
    begin
      int unsigned act;
      act = 0;
      for (int n = 0; n < 20; n++) begin
        @(negedge clk);
        if (bus.wr_en !== 1'b0 || bus.done !== 1'b0 || bus.rd_en !== 1'b0) act++;
      end
      chk("quiet_after_reset", act, 0);
    end
    mon_en = 1'b1;

    // Full transform after the abort.
    run_transform(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("done_count_post_reset", done_cnt, 1);
    repeat (6) @(negedge clk);
    chk("rd_queue_empty", 32'(exp_rd.size()), 0);
    chk("wr_queue_empty", 32'(exp_wr.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ntt_r4_sched.md
Name: ntt_r4_sched

Overview:
- Stage scheduler for the 4-PE radix-4 butterfly array of the NTT core.
- Sequences all radix-4 stages of one N-point transform (forward NTT or inverse NTT) and drives the array's mode select.
- Generates coefficient-memory read addresses, twiddle-ROM addresses and delayed write-back addresses.
- Enforces a pipeline drain between stages so no stage reads data still in flight.

Parameters:
- N_LOG2, 8, log2 of transform length (even; N=256).
- STAGES, N_LOG2/2, number of radix-4 stages (4).
- ADDR_W, N_LOG2-2, width of the per-stage group counter and memory address (6).
- TW_W, 7, twiddle ROM address width (holds (4^STAGES-1)/3 = 85 entries).
- BF_LAT, 4, cycles from rd_en to valid butterfly output at the write port (memory read plus PE pipeline).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin a transform; sampled only in IDLE.
- mode  in  1  0 = forward NTT, 1 = inverse NTT; latched on accepted start.
- busy  out  1  high from accepted start until the done pulse.
- done  out  1  one-cycle pulse after the last write-back.
- sel  out  1  butterfly array mode; equals the latched mode and is held for the whole transform.
- stage  out  2  current stage index, 0..STAGES-1.
- rd_en  out  1  read strobe to the 4-bank coefficient memory.
- rd_addr  out  ADDR_W  group index of the 4 coefficients read this cycle.
- tw_addr  out  TW_W  twiddle ROM address (wa1/wa2/wa3 triple) aligned with rd_addr.
- wr_en  out  1  write strobe for butterfly results.
- wr_addr  out  ADDR_W  rd_addr delayed by BF_LAT cycles.

Behaviour:
- Reset: clk and rst only; reset is asynchronous and active-low (rst=0 resets).
  - While rst=0: state=IDLE; busy, done, sel, rd_en and wr_en are 0; stage, rd_addr, tw_addr and wr_addr are 0; delay line cleared.
- States:
  - IDLE: start=1 latches mode, sets stage=0 and cnt=0, goes to RUN; busy rises the next cycle.
  - RUN: rd_en=1 and rd_addr=cnt; cnt increments each cycle. At cnt=2^ADDR_W-1 go to DRAIN and deassert rd_en the following cycle.
  - DRAIN: wait BF_LAT cycles so the last wr_en of the stage has occurred.
    - If stage<STAGES-1: stage+1, cnt=0, back to RUN.
    - Else go to FINISH.
  - FINISH: done=1 for one cycle, busy=0 in the same cycle, go to IDLE.
- Per-stage cycle count: 2^ADDR_W RUN cycles plus BF_LAT DRAIN cycles.
- Transform latency, start to done: 1 + STAGES*(2^ADDR_W+BF_LAT) + 1 cycles, i.e. 274 with defaults.
- Twiddle addressing, stage s (forward):
  - tw_addr = base(s) + (cnt >> 2*(STAGES-1-s)).
  - base(s) = (4^s-1)/3, giving bases 0, 1, 5, 21 for s=0..3.
- Twiddle addressing, inverse (mode=1): stages run in the same order, and tw_addr = 84 - forward address. The inverse twiddle table is stored reversed in the same ROM.
- Write-back delay line: an (ADDR_W+1)-bit shift register of depth BF_LAT carrying {rd_en, rd_addr}.
  - Its output is {wr_en, wr_addr}.
  - It is not cleared between stages; the drain guarantees it is empty at each stage boundary.
- Port semantics:
  - start while busy is ignored.
  - start asserted in the same cycle as done is ignored, because state is FINISH, not IDLE.
  - mode changes after an accepted start have no effect until the next transform.
- Reset mid-operation returns immediately to IDLE with every output at its reset value. No partial write-back and no done pulse follow.
- Counter wrap: cnt is ADDR_W bits wide and the stage boundary is detected at all-ones. The counter is never allowed to wrap inside RUN.

Decomposition:
- Shared package ntt_pkg:
  - N_LOG2, STAGES, ADDR_W, TW_W.
  - The tw_base function, (4^s-1)/3.
  - State encoding IDLE/RUN/DRAIN/FINISH.
  - Mode constants MODE_NTT=0 and MODE_INTT=1.
- One sub-module, sched_delay_line, parameterised by width and depth, provides the BF_LAT alignment.
  - It is reused later to align twiddles if ROM latency changes.

Test Plan:
- Reset then start=1 for one cycle with mode=0:
  - busy=1 from the next cycle.
  - 256 rd_en cycles in total, in 4 bursts of 64.
  - rd_addr counts 0..63 in each burst.
  - done pulses exactly 274 cycles after start.
- Forward tw_addr per stage:
  - stage 0: constant 0.
  - stage 1: 1..4, changing every 16 cycles.
  - stage 2: 5..20, changing every 4 cycles.
  - stage 3: 21..84, changing every cycle.
- mode=1 run:
  - sel=1 throughout the transform.
  - stage 0 tw_addr = 84.
  - stage 3 first tw_addr = 63 and last tw_addr = 0.
- Alignment and drain:
  - wr_en/wr_addr equal rd_en/rd_addr delayed by exactly 4 cycles.
  - The last wr_en of stage k precedes the first rd_en of stage k+1.
- start pulsed during busy, and start held high across the done cycle:
  - Neither is accepted.
  - A start one cycle after done is accepted.
- rst=0 asserted in stage 2 at cnt=30:
  - All outputs go to 0 asynchronously.
  - No done pulse and no wr_en afterwards.
  - A subsequent start runs a full, correct transform.
